ball_motion_ctrl: RTL
=====================

// Module: ball_motion_ctrl
// PURPOSE
//   Owns the maze ball position. Once per video frame it takes the direction from the
//   motion-sensor decode and steps the ball one pixel at a time.
//   Before each step it checks the stop_* flags from the maze wall/collision portions.
//   Drives x_ball/y_ball/ball_width back into those portions and into the pixel renderer.
// PARAMETERS
//   START_X     20   ball x after reset/restart (pixels, top-left corner)
//   START_Y     300  ball y after reset/restart
//   BALL_W      8    ball side length, driven on ball_width
//   STEP_PIX    4    max pixels moved per frame tick (1..15)
//   X_MIN/X_MAX 0/631  legal range of x_ball (inclusive)
//   Y_MIN/Y_MAX 0/471  legal range of y_ball (inclusive)
//   GOAL_X0/X1  482/492  goal window x (inclusive), GOAL_Y0/Y1 20/46 goal window y
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous, active-high reset
//   frame_tick   in   1   1-cycle pulse per frame (start of vertical blank)
//   restart      in   1   1-cycle pulse: return ball to start, clear goal
//   dir_right    in   1   motion request, level, sampled at frame_tick
//   dir_left     in   1   "
//   dir_down     in   1   "
//   dir_up       in   1   "
//   stop_right   in   1   OR of all portions' stop_right (combinational from x/y_ball)
//   stop_left    in   1   "
//   stop_down    in   1   "
//   stop_up      in   1   "
//   x_ball       out  11  ball x, registered
//   y_ball       out  11  ball y, registered
//   ball_width   out  5   constant BALL_W
//   busy         out  1   high while a frame's move is in progress
//   blocked      out  1   1-cycle pulse when a step is refused (wall or boundary)
//   goal         out  1   sticky: ball top-left inside goal window
// BEHAVIOUR
//   Reset (rst=1 at posedge): x_ball=START_X, y_ball=START_Y, busy=0, blocked=0, goal=0, FSM=IDLE.
//   Direction latch at frame_tick: one axis only, priority right>left>down>up.
//     No request -> stay IDLE.
//   FSM (state updates on clk):
//     IDLE  : frame_tick & request -> latch dir, rem=STEP_PIX, busy=1 -> SETTLE
//     SETTLE: 1 wait cycle so stop_* settle on the current x/y -> STEP
//     STEP  : refuse the step if stop_<dir>=1, or if the move would leave [MIN,MAX].
//               Refused -> blocked=1 for 1 cycle, busy=0 -> IDLE.
//             Otherwise move 1 px in dir; rem=rem-1.
//               rem==0 after the move -> busy=0 -> IDLE; else -> SETTLE.
//   Step latency: 2 clk per pixel. Frame move done <= 2*STEP_PIX+1 cycles after frame_tick.
//   frame_tick while busy: ignored, no queueing.
//   restart: any state -> start position, goal=0, busy=0 -> IDLE next cycle.
//     restart wins over a simultaneous frame_tick.
//   goal: set at the cycle x/y enter the goal window; holds until rst/restart.
//     While goal=1, frame_ticks are ignored (ball frozen).
//   Arithmetic: unsigned 11-bit. Boundary compare happens before the update, so no
//     wrap-around (x_ball=0 moving left is refused).
//   blocked and the position update never occur in the same cycle.
// TESTING
//   1 reset -> x_ball=20, y_ball=300, ball_width=8, busy=0, goal=0
//   2 free move: dir_right=1, stop_*=0, one frame_tick -> x_ball=24 after 9 cycles,
//     busy low at the same cycle, blocked never pulses
//   3 wall: stop_right forced 1 once x_ball reaches 22 -> final x_ball=22, blocked
//     pulses 1 cycle, y_ball unchanged
//   4 boundary: x_ball=1, dir_left, tick -> x_ball=0, then blocked; a second tick
//     -> x_ball stays 0, blocked pulses again
//   5 priority/overlap: dir_right & dir_up at the tick -> only x changes; a tick
//     inside busy has no effect (total move 4 px)
//   6 goal/restart: drive ball to (484,30) -> goal=1, further ticks ignored;
//     restart pulse -> (20,300), goal=0

Source files
------------

// File: rtl/ball_motion_ctrl.sv
// Maze ball position owner: one frame tick requests up to STEP_PIX single-pixel steps,
// each preceded by a settle cycle so the wall stop_* flags reflect the current position.
module ball_motion_ctrl #(
  parameter int START_X  = 20,
  parameter int START_Y  = 300,
  parameter int BALL_W   = 8,
  parameter int STEP_PIX = 4,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 631,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 471,
  parameter int GOAL_X0  = 482,
  parameter int GOAL_X1  = 492,
  parameter int GOAL_Y0  = 20,
  parameter int GOAL_Y1  = 46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        restart,
  input  logic        dir_right,
  input  logic        dir_left,
  input  logic        dir_down,
  input  logic        dir_up,
  input  logic        stop_right,
  input  logic        stop_left,
  input  logic        stop_down,
  input  logic        stop_up,
  output logic [10:0] x_ball,
  output logic [10:0] y_ball,
  output logic [4:0]  ball_width,
  output logic        busy,
  output logic        blocked,
  output logic        goal
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STEP} state_t;
  typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_DOWN, D_UP} dir_t;

  localparam logic [10:0] START_X_L = 11'(START_X);
  localparam logic [10:0] START_Y_L = 11'(START_Y);
  localparam logic [10:0] X_MIN_L   = 11'(X_MIN);
  localparam logic [10:0] X_MAX_L   = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_L   = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_L   = 11'(Y_MAX);
  localparam logic [10:0] GOAL_X0_L = 11'(GOAL_X0);
  localparam logic [10:0] GOAL_X1_L = 11'(GOAL_X1);
  localparam logic [10:0] GOAL_Y0_L = 11'(GOAL_Y0);
  localparam logic [10:0] GOAL_Y1_L = 11'(GOAL_Y1);
  localparam logic [3:0]  STEP_L    = 4'(STEP_PIX);

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [3:0]  rem_q, rem_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        blocked_q, blocked_d;
  logic        goal_q, goal_d;
  logic        refuse;
  logic        any_req;

  assign any_req = dir_right | dir_left | dir_down | dir_up;

  // Bounds are checked on the current position, so an edge pixel never wraps.
  always_comb begin
    refuse = 1'b0;
    case (dir_q)
      D_RIGHT: refuse = stop_right | (x_q >= X_MAX_L);
      D_LEFT:  refuse = stop_left  | (x_q <= X_MIN_L);
      D_DOWN:  refuse = stop_down  | (y_q >= Y_MAX_L);
      D_UP:    refuse = stop_up    | (y_q <= Y_MIN_L);
      default: refuse = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rem_d     = rem_q;
    x_d       = x_q;
    y_d       = y_q;
    blocked_d = 1'b0;
    if (restart) begin
      state_d = S_IDLE;
      x_d     = START_X_L;
      y_d     = START_Y_L;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_tick && any_req && !goal_q) begin
            if (dir_right)     dir_d = D_RIGHT;
            else if (dir_left) dir_d = D_LEFT;
            else if (dir_down) dir_d = D_DOWN;
            else               dir_d = D_UP;
            rem_d   = STEP_L;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: state_d = S_STEP;
        S_STEP: begin
          if (refuse) begin
            blocked_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            case (dir_q)
              D_RIGHT: x_d = x_q + 11'd1;
              D_LEFT:  x_d = x_q - 11'd1;
              D_DOWN:  y_d = y_q + 11'd1;
              default: y_d = y_q - 11'd1;
            endcase
            rem_d   = rem_q - 4'd1;
            state_d = (rem_q == 4'd1) ? S_IDLE : S_SETTLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Goal is judged on the position being written, so it rises with the entering step.
    goal_d = !restart & (goal_q |
             ((x_d >= GOAL_X0_L) && (x_d <= GOAL_X1_L) &&
              (y_d >= GOAL_Y0_L) && (y_d <= GOAL_Y1_L)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dir_q     <= D_RIGHT;
      rem_q     <= 4'd0;
      x_q       <= START_X_L;
      y_q       <= START_Y_L;
      blocked_q <= 1'b0;
      goal_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      x_q       <= x_d;
      y_q       <= y_d;
      blocked_q <= blocked_d;
      goal_q    <= goal_d;
    end
  end

  assign x_ball     = x_q;
  assign y_ball     = y_q;
  assign ball_width = 5'(BALL_W);
  assign busy       = (state_q != S_IDLE);
  assign blocked    = blocked_q;
  assign goal       = goal_q;

endmodule
